// File: rtl/lsu_axi_master_if.sv
// AXI4-lite master/slave bundle (no response codes) between the LSU bridge and the memory slaves.
interface lsu_axi_master_if;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, arready, rvalid, rdata
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, arready, rvalid, rdata
    );
endinterface

// File: rtl/lsu_axi_master.sv
// Bridges the core's single-outstanding load/store port onto AXI4-lite, one transaction in flight.
//
// state | meaning
// IDLE  | waiting for a core request (req_ready high)
// WR    | AW and W presented; each valid drops independently on its handshake
// WRESP | both write channels done, bready high, waiting for B
// RD_A  | AR presented, waiting for arready
// RD_D  | rready high, waiting for R
// RSP   | response held on rsp_* until the core takes it
module lsu_axi_master #(
    parameter logic [2:0] PROT              = 3'b000,
    parameter bit         WDATA_ON_READ_RSP = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    lsu_axi_master_if.master axi
);

    typedef enum logic [2:0] {IDLE, WR, WRESP, RD_A, RD_D, RSP} state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        bready_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        aw_done;
    logic        w_done;

    logic aw_hs;
    logic w_hs;

    assign aw_hs = awvalid_q & axi.awready;
    assign w_hs  = wvalid_q & axi.wready;

    assign req_ready   = (state == IDLE) & ~reset;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;

    assign axi.awvalid = awvalid_q;
    assign axi.awaddr  = addr_q;
    assign axi.awprot  = PROT;
    assign axi.wvalid  = wvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.bready  = bready_q;
    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = addr_q;
    assign axi.arprot  = PROT;
    assign axi.rready  = rready_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr;
                        if (req_we) begin
                            wdata_q   <= req_wdata;
                            wstrb_q   <= req_wstrb;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done   <= 1'b0;
                            w_done    <= 1'b0;
                            state     <= WR;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= RD_A;
                        end
                    end
                end
                WR: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    // Done flags cover the earlier channel, live handshakes the one finishing now.
                    if ((aw_done | aw_hs) & (w_done | w_hs)) begin
                        bready_q <= 1'b1;
                        state    <= WRESP;
                    end
                end
                WRESP: begin
                    if (axi.bvalid & bready_q) begin
                        bready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= WDATA_ON_READ_RSP ? wdata_q : 32'h0;
                        state       <= RSP;
                    end
                end
                RD_A: begin
                    if (arvalid_q & axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= RD_D;
                    end
                end
                RD_D: begin
                    if (axi.rvalid & rready_q) begin
                        rready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= axi.rdata;
                        state       <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    // A response arriving while not waiting for it is a slave protocol error.
    bvalid_only_in_wresp: assert property (@(posedge clk) disable iff (reset)
        axi.bvalid |-> (state == WRESP));
    rvalid_only_in_rd_d: assert property (@(posedge clk) disable iff (reset)
        axi.rvalid |-> (state == RD_D));
`endif

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed vectors, corner sequences and a randomized AXI4-lite slave checked against a transaction scoreboard.
module tb_lsu_axi_master;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;

    always #5 clk = ~clk;

    lsu_axi_master_if axi ();

    lsu_axi_master #(.PROT(3'b000), .WDATA_ON_READ_RSP(1'b0)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .axi(axi.master)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // slave knobs and state
    bit          rand_mode = 0;
    bit          f_awready = 1, f_wready = 1, f_arready = 1, r_hold = 0;
    logic [31:0] f_rdata = 32'h0;
    bit          aw_got, w_got, ar_got;
    int          b_wait, r_wait;

    // scoreboard
    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rd;
        bit          aw_seen;
        bit          w_seen;
        bit          bus_done;
    } txn_t;
    txn_t q[$];
    int   proto_err = 0;
    int   cyc = 0;
    int   req_count = 0, resp_count = 0;
    int   n_arv, n_awv, n_wv, aw_hs_cyc, w_hs_cyc;

    bit          pv = 0;
    logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rspv, p_rspr;
    logic [31:0] p_awaddr, p_wdata, p_araddr, p_rsp;
    logic [3:0]  p_wstrb;

    task automatic violation(input string what);
        proto_err++;
        $display("[TB] protocol violation at cycle %0d: %s", cyc, what);
    endtask

    task automatic clear_slave();
        axi.bvalid = 0; axi.rvalid = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_wait = 0; r_wait = 0;
    endtask

    task automatic cycle();
        bit   aw_hs, w_hs, b_hs, ar_hs, r_hs, acc, rsp_hs;
        txn_t t;
        aw_hs  = axi.awvalid & axi.awready;
        w_hs   = axi.wvalid & axi.wready;
        b_hs   = axi.bvalid & axi.bready;
        ar_hs  = axi.arvalid & axi.arready;
        r_hs   = axi.rvalid & axi.rready;
        acc    = req_valid & req_ready;
        rsp_hs = rsp_valid & rsp_ready;
        if (reset) begin
            pv = 0;
            q.delete();
        end else begin
            if (pv) begin
                if (p_awv && !p_awr && (!axi.awvalid || axi.awaddr !== p_awaddr)) violation("aw dropped/changed");
                if (p_wv && !p_wr && (!axi.wvalid || axi.wdata !== p_wdata || axi.wstrb !== p_wstrb)) violation("w dropped/changed");
                if (p_arv && !p_arr && (!axi.arvalid || axi.araddr !== p_araddr)) violation("ar dropped/changed");
                if (p_rspv && !p_rspr && (!rsp_valid || rsp_rdata !== p_rsp)) violation("rsp dropped/changed");
            end
            if (axi.awprot !== 3'b000 || axi.arprot !== 3'b000) violation("prot");
            if (axi.awvalid) n_awv++;
            if (axi.wvalid) n_wv++;
            if (axi.arvalid) n_arv++;
            if (axi.bready && (q.size() == 0 || !(q[0].aw_seen && q[0].w_seen))) violation("bready early");
            if (rsp_hs) begin
                if (q.size() == 0) violation("response without request");
                else begin
                    t = q.pop_front();
                    if (!t.bus_done) violation("response before bus completion");
                    check("rsp_rdata", rsp_rdata, t.we ? 32'h0 : t.rd);
                    resp_count++;
                end
            end
            if (acc) begin
                t = '{we: req_we, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb,
                      rd: 32'h0, aw_seen: 0, w_seen: 0, bus_done: 0};
                q.push_back(t);
                req_count++;
            end
            if (aw_hs || w_hs || b_hs || ar_hs || r_hs) begin
                if (q.size() == 0) violation("bus activity without request");
                else begin
                    t = q[0];
                    if (aw_hs) begin
                        if (!t.we || axi.awaddr !== t.addr) violation("awaddr");
                        t.aw_seen = 1; aw_hs_cyc = cyc;
                    end
                    if (w_hs) begin
                        if (!t.we || axi.wdata !== t.wdata || axi.wstrb !== t.wstrb) violation("wdata/wstrb");
                        t.w_seen = 1; w_hs_cyc = cyc;
                    end
                    if (b_hs) t.bus_done = 1;
                    if (ar_hs && (t.we || axi.araddr !== t.addr)) violation("araddr");
                    if (r_hs) begin
                        t.rd = axi.rdata; t.bus_done = 1;
                    end
                    q[0] = t;
                end
            end
            pv = 1;
            p_awv = axi.awvalid; p_awr = axi.awready; p_awaddr = axi.awaddr;
            p_wv = axi.wvalid; p_wr = axi.wready; p_wdata = axi.wdata; p_wstrb = axi.wstrb;
            p_arv = axi.arvalid; p_arr = axi.arready; p_araddr = axi.araddr;
            p_rspv = rsp_valid; p_rspr = rsp_ready; p_rsp = rsp_rdata;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            clear_slave();
        end else begin
            if (b_hs) begin axi.bvalid = 0; aw_got = 0; w_got = 0; end
            if (aw_hs) aw_got = 1;
            if (w_hs) w_got = 1;
            if (aw_got && w_got && !axi.bvalid) begin
                if (b_wait <= 0) begin
                    axi.bvalid = 1;
                    b_wait = rand_mode ? int'($urandom_range(0, 3)) : 0;
                end else b_wait--;
            end
            if (r_hs) begin axi.rvalid = 0; ar_got = 0; end
            if (ar_hs) ar_got = 1;
            if (!axi.rvalid && rand_mode) axi.rdata = $urandom;
            if (ar_got && !axi.rvalid && !r_hold) begin
                if (r_wait <= 0) begin
                    axi.rvalid = 1;
                    axi.rdata = rand_mode ? $urandom : f_rdata;
                    r_wait = rand_mode ? int'($urandom_range(0, 3)) : 0;
                end else r_wait--;
            end
        end
        axi.awready = rand_mode ? 1'($urandom_range(0, 1)) : f_awready;
        axi.wready  = rand_mode ? 1'($urandom_range(0, 1)) : f_wready;
        axi.arready = rand_mode ? 1'($urandom_range(0, 1)) : f_arready;
    endtask

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] slave_rdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_arv;
        int          exp_awv;
    } vec_t;

    task automatic run_vec(input vec_t v, input string tag);
        int k;
        int lat;
        f_rdata = v.slave_rdata;
        f_awready = 1; f_wready = 1; f_arready = 1;
        axi.awready = 1; axi.wready = 1; axi.arready = 1;
        rsp_ready = 1;
        n_arv = 0; n_awv = 0; n_wv = 0; aw_hs_cyc = -1; w_hs_cyc = -2;
        req_valid = 1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_wstrb = v.wstrb;
        k = 0;
        while (!req_ready && k < 20) begin cycle(); k++; end
        cycle();
        req_valid = 0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin cycle(); lat++; end
        check({tag, "_latency"}, lat, v.exp_lat);
        check({tag, "_rdata"}, rsp_rdata, v.exp_rdata);
        check({tag, "_arvalid_cycles"}, n_arv, v.exp_arv);
        check({tag, "_awvalid_cycles"}, n_awv, v.exp_awv);
        check({tag, "_wvalid_cycles"}, n_wv, v.exp_awv);
        if (v.we) check({tag, "_aw_w_same_cycle"}, aw_hs_cyc, w_hs_cyc);
        cycle();
        check({tag, "_back_to_idle"}, {31'b0, req_ready}, 1);
    endtask

    vec_t vecs[5];

    initial begin
        int k;
        int base_req, base_rsp, guard;
        logic [31:0] held;

        vecs[0] = '{0, 32'h0000_1000, 32'h0, 4'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3, 1, 0};
        vecs[1] = '{1, 32'h0000_2004, 32'h1234_5678, 4'b0011, 32'hA5A5_A5A5, 32'h0, 3, 0, 1};
        vecs[2] = '{0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 1, 0};
        vecs[3] = '{1, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 32'h0, 32'h0, 3, 0, 1};
        vecs[4] = '{0, 32'h0000_0004, 32'h0, 4'h0, 32'h0000_0001, 32'h0000_0001, 3, 1, 0};

        reset = 1;
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0; rsp_ready = 1;
        axi.awready = 1; axi.wready = 1; axi.arready = 1; axi.rdata = 0;
        clear_slave();
        repeat (2) cycle();
        check("reset_req_ready_low", {31'b0, req_ready}, 0);
        reset = 0;
        #1;
        check("reset_req_ready", {31'b0, req_ready}, 1);
        check("reset_valids", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, rsp_valid}, 0);
        check("reset_rsp_rdata", rsp_rdata, 0);
        check("reset_awaddr", axi.awaddr, 0);
        check("reset_wdata", axi.wdata, 0);
        check("reset_wstrb", {28'b0, axi.wstrb}, 0);

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // store with AW stalled while W completes at once
        f_awready = 0; f_wready = 1; axi.awready = 0; axi.wready = 1;
        req_valid = 1; req_we = 1; req_addr = 32'h3008; req_wdata = 32'hCAFE_0001; req_wstrb = 4'hC;
        k = 0;
        while (!req_ready && k < 20) begin cycle(); k++; end
        cycle();
        req_valid = 0;
        check("skew_both_valid", {30'b0, axi.awvalid, axi.wvalid}, 3);
        cycle();
        check("skew_wvalid_dropped", {31'b0, axi.wvalid}, 0);
        for (int i = 0; i < 3; i++) begin
            check("skew_awvalid_held", {31'b0, axi.awvalid}, 1);
            check("skew_awaddr_stable", axi.awaddr, 32'h3008);
            check("skew_no_bready", {31'b0, axi.bready}, 0);
            cycle();
        end
        f_awready = 1; axi.awready = 1;
        cycle();
        check("skew_bready_after_aw", {31'b0, axi.bready}, 1);
        k = 0;
        while (!rsp_valid && k < 20) begin cycle(); k++; end
        check("skew_rsp_rdata", rsp_rdata, 0);
        cycle();

        // response back-pressure with a new request waiting
        f_awready = 1; f_wready = 1; f_rdata = 32'h0BAD_F00D;
        rsp_ready = 0;
        req_valid = 1; req_we = 0; req_addr = 32'h5000;
        k = 0;
        while (!req_ready && k < 20) begin cycle(); k++; end
        cycle();
        req_addr = 32'h6000;
        k = 0;
        while (!rsp_valid && k < 20) begin cycle(); k++; end
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid_hold", {31'b0, rsp_valid}, 1);
            check("bp_rsp_rdata_hold", rsp_rdata, 32'h0BAD_F00D);
            check("bp_req_ready_low", {31'b0, req_ready}, 0);
            cycle();
        end
        rsp_ready = 1;
        check("bp_no_accept_in_rsp_cycle", {31'b0, req_ready}, 0);
        f_rdata = 32'h1357_9BDF;
        cycle();
        check("bp_ready_after_rsp", {31'b0, req_ready}, 1);
        cycle();
        req_valid = 0;
        check("bp_second_arvalid", {31'b0, axi.arvalid}, 1);
        check("bp_second_araddr", axi.araddr, 32'h6000);
        k = 0;
        while (!rsp_valid && k < 20) begin cycle(); k++; end
        check("bp_second_rdata", rsp_rdata, 32'h1357_9BDF);
        cycle();

        // reset while waiting for R
        r_hold = 1;
        req_valid = 1; req_we = 0; req_addr = 32'h7000;
        k = 0;
        while (!axi.rready && k < 20) begin cycle(); req_valid = 0; k++; end
        check("rst_reached_rd_d", {31'b0, axi.rready}, 1);
        #2 reset = 1;
        #1;
        check("rst_async_valids", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, rsp_valid}, 0);
        check("rst_async_req_ready", {31'b0, req_ready}, 0);
        cycle();
        cycle();
        check("rst_held_valids", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, rsp_valid}, 0);
        reset = 0;
        r_hold = 0;
        #1;
        check("rst_release_req_ready", {31'b0, req_ready}, 1);
        run_vec(vecs[0], "post_reset");

        // randomized slave and core traffic
        rand_mode = 1;
        base_req = req_count;
        base_rsp = resp_count;
        guard = 0;
        while ((resp_count - base_rsp) < 1000 && guard < 60000) begin
            cycle();
            guard++;
            if ((req_count - base_req) < 1000) begin
                req_valid = 1'($urandom_range(0, 1));
                req_we    = 1'($urandom_range(0, 1));
                req_addr  = $urandom & 32'hFFFF_FFFC;
                req_wdata = $urandom;
                req_wstrb = 4'($urandom_range(0, 15));
            end else req_valid = 0;
            rsp_ready = 1'($urandom_range(0, 1));
        end
        held = resp_count - base_rsp;
        check("rand_responses", held, 1000);
        check("rand_requests", req_count - base_req, 1000);
        check("rand_none_outstanding", q.size(), 0);
        rand_mode = 0;
        req_valid = 0;
        rsp_ready = 1;
        repeat (3) cycle();

        check("axi_protocol_errors", proto_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/lsu_axi_master.md
Name: lsu_axi_master

Overview:
- Upstream neighbour of the AXI4-lite slaves on the core memory bus.
- Converts the core's single-outstanding load/store request port into AXI4-lite master transactions.
- Issues AW/W or AR, waits for B or R, and returns one response per request to the core.
- Allows one transaction in flight; it is the only master driving the slave-side AXI4-lite signals.

Parameters:
- PROT, 3'b000, constant value driven on awprot and arprot.
- WDATA_ON_READ_RSP, 1'b0: if 1, write responses return the written data on rsp_rdata; if 0, rsp_rdata reads 0 on write responses.

Ports:
- clk  input  1  single clock; all logic on its rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  core request valid
- req_ready  output  1  core request accepted when req_valid&req_ready
- req_we  input  1  1=store, 0=load
- req_addr  input  32  byte address
- req_wdata  input  32  store data
- req_wstrb  input  4  store byte enables
- rsp_valid  output  1  response available
- rsp_ready  input  1  core consumes response
- rsp_rdata  output  32  load data
- awvalid/awready/awaddr/awprot  out/in/out/out  1/1/32/3  AXI4-lite write address
- wvalid/wready/wdata/wstrb  out/in/out/out  1/1/32/4  AXI4-lite write data
- bvalid/bready  in/out  1/1  AXI4-lite write response (no bresp)
- arvalid/arready/araddr/arprot  out/in/out/out  1/1/32/3  AXI4-lite read address
- rvalid/rready/rdata  in/out/in  1/1/32  AXI4-lite read data (no rresp)

Behaviour:
- Reset (async, reset=1): state=IDLE. awvalid, wvalid, bready, arvalid, rready and rsp_valid are 0. rsp_rdata=0. Internal address/data/strb registers are 0.
- req_ready = (state==IDLE) & ~reset. It is combinational from the state only; no combinational path from req_valid.
- All AXI outputs are registered. addr/data/strb are captured on request acceptance and held stable until the matching handshake.
- States: IDLE, WR, WRESP, RD_A, RD_D, RSP.
- IDLE, on req_valid & req_we:
  - capture addr, wdata, wstrb; go to WR.
  - Next cycle awvalid=1 and wvalid=1 together.
- IDLE, on req_valid & ~req_we:
  - capture addr; go to RD_A.
  - Next cycle arvalid=1.
- WR: awvalid drops the cycle after aw handshake; wvalid drops the cycle after w handshake. Either order or the same cycle is legal. Once both are done (done flags or same-cycle handshakes), go to WRESP with bready=1.
- WRESP: on bvalid&bready, set bready=0, set rsp_valid=1, set rsp_rdata per WDATA_ON_READ_RSP; go to RSP.
- RD_A: on arvalid&arready, set arvalid=0, rready=1; go to RD_D.
- RD_D: on rvalid&rready, capture rdata into rsp_rdata, set rready=0, rsp_valid=1; go to RSP.
- RSP: hold rsp_valid and rsp_rdata stable until rsp_ready. On rsp_valid&rsp_ready, set rsp_valid=0 and go to IDLE. The next request is accepted no earlier than the following cycle.
- Latency: with a zero-wait slave, a load returns rsp_valid 3 cycles after request acceptance (accept→AR→R→RSP). A store returns 3 cycles after acceptance (accept→AW/W→B→RSP).
- AXI rules:
  - A valid is never deasserted before its handshake.
  - Address, data and strobe do not change while their valid is high.
  - bready is asserted only after both AW and W complete.
  - A bvalid/rvalid seen outside WRESP/RD_D is ignored; it is a protocol error and an assertion fires in simulation.
- Reset mid-operation aborts immediately to IDLE with all valids 0. Slave-side recovery is the system's concern; the slaves share the reset.
- Inputs req_* are ignored outside IDLE.

Test Plan:
- Load, zero-wait slave: req addr=0x1000, we=0; slave rdata=0xDEADBEEF → araddr=0x1000 with arvalid 1 cycle; rsp_valid 3 cycles after accept; rsp_rdata=0xDEADBEEF.
- Store, zero-wait slave: addr=0x2004, wdata=0x12345678, wstrb=4'b0011 → awaddr/wdata/wstrb match while valid; awvalid and wvalid handshake in the same cycle; bready rises only after both complete; one rsp_valid with rsp_rdata=0.
- Store, skewed: wready=1 at cycle 1, awready held 0 for 4 cycles → wvalid drops after cycle 1; awvalid stays high with a stable awaddr until its handshake; bready is not asserted before then.
- Back-pressure: rsp_ready=0 for 5 cycles after a load → rsp_valid and rsp_rdata hold; req_ready stays 0; a new req_valid is not accepted until the cycle after rsp_ready.
- Random slave (random ready delays, random rdata) for 1000 mixed requests → exactly one response per request; load data equals the slave's rdata at the R handshake; the AXI stability assertions never fire.
- Reset asserted mid-RD_D → all AXI valids/readies and rsp_valid are 0 while reset is held; after release req_ready=1 and a fresh load completes normally.
